// File: rtl/led_flash_pkg.sv
// ---------------------------------------------------------------------------
// led_flash_pkg
// Shared definitions for the 4-channel LED flash block:
//   - state_e     : per-channel state encoding (IDLE / ON / GAP)
//   - NUM_CH      : number of LED channels
//   - cnt_width() : width of the hold/gap tick counter
//   - pend_width(): width of the pending-flash counter
// ---------------------------------------------------------------------------
package led_flash_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Counter must hold the larger of the two tick reload values.
  function automatic int unsigned cnt_width(input int unsigned hold_ticks,
                                            input int unsigned gap_ticks);
    int unsigned max_v;
    if (hold_ticks > gap_ticks) begin
      max_v = hold_ticks;
    end else begin
      max_v = gap_ticks;
    end
    return $clog2(max_v + 1);
  endfunction

  // Pending counter must hold 0..max_pend.
  function automatic int unsigned pend_width(input int unsigned max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/led_flash_ch.sv
// ---------------------------------------------------------------------------
// led_flash_ch
// Single LED channel: each strobe queues one flash (HOLD_TICKS ce-ticks on,
// then GAP_TICKS ce-ticks off). Strobes arriving while a flash is running are
// queued up to MAX_PEND; a strobe beyond that is dropped and flagged on ovf.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   ce    in  timing tick, advances the hold/gap counter
//   clr   in  synchronous clear (priority over st and ce)
//   st    in  strobe, one flash request per high cycle
//   led   out LED drive (registered, high while ON)
//   busy  out channel not idle (registered)
//   ovf   out one-cycle pulse when a strobe was dropped
// ---------------------------------------------------------------------------
module led_flash_ch
  import led_flash_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned GAP_TICKS  = 4,
  parameter int unsigned MAX_PEND   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic clr,
  input  logic st,
  output logic led,
  output logic busy,
  output logic ovf
);

  localparam int unsigned CW = cnt_width(HOLD_TICKS, GAP_TICKS);
  localparam int unsigned PW = pend_width(MAX_PEND);

  localparam logic [CW-1:0] HOLD_C   = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] GAP_C    = CW'(GAP_TICKS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);
  localparam logic [PW-1:0] PEND_ZERO = PW'(0);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  pend_q, pend_d;
  logic           led_q, led_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;

  // Next-state, counter, queue and output decode for the channel.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;

    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
      pend_d  = PEND_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (st) begin
            state_d = ST_ON;
            cnt_d   = HOLD_C;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_ON: begin
          if (ce) begin
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              state_d = ST_GAP;
              cnt_d   = GAP_C;
            end
          end else begin
            cnt_d = cnt_q;
          end
          if (st) begin
            if (pend_q < PEND_MAX) begin
              pend_d = pend_q + PEND_ONE;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            pend_d = pend_q;
          end
        end

        ST_GAP: begin
          if (ce && (cnt_q <= CNT_ONE)) begin
            // Gap exit: a strobe on this edge replaces the consumed slot,
            // so a full queue stays full without raising ovf.
            if ((pend_q != PEND_ZERO) || st) begin
              state_d = ST_ON;
              cnt_d   = HOLD_C;
              if (st) begin
                pend_d = pend_q;
              end else begin
                pend_d = pend_q - PEND_ONE;
              end
            end else begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end
          end else begin
            if (ce) begin
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              cnt_d = cnt_q;
            end
            if (st) begin
              if (pend_q < PEND_MAX) begin
                pend_d = pend_q + PEND_ONE;
              end else begin
                ovf_d = 1'b1;
              end
            end else begin
              pend_d = pend_q;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          pend_d  = PEND_ZERO;
        end
      endcase
    end

    // Outputs follow the next state so the LED lights on the strobe edge.
    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      pend_q  <= PEND_ZERO;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/led4_flash_bl.sv
// ---------------------------------------------------------------------------
// led4_flash_bl
// Four independent LED flash channels driven by single-cycle button strobes.
// Wiring only; all behaviour lives in led_flash_ch.
// Ports:
//   clk   in      system clock
//   rst_n in      asynchronous active-low reset
//   ce    in      timing tick shared by all channels
//   clr   in      synchronous clear of all channels
//   st    in  [4] per-channel strobes
//   led   out [4] registered LED drive
//   busy  out [4] registered channel-busy flags
//   ovf   out [4] one-cycle dropped-strobe pulses
// ---------------------------------------------------------------------------
module led4_flash_bl
  import led_flash_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned GAP_TICKS  = 4,
  parameter int unsigned MAX_PEND   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              clr,
  input  logic [NUM_CH-1:0] st,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] ovf
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_flash_ch #(
      .HOLD_TICKS (HOLD_TICKS),
      .GAP_TICKS  (GAP_TICKS),
      .MAX_PEND   (MAX_PEND)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .clr   (clr),
      .st    (st[g]),
      .led   (led[g]),
      .busy  (busy[g]),
      .ovf   (ovf[g])
    );
  end

endmodule

// File: tb/tb_led4_flash_bl.sv
// ---------------------------------------------------------------------------
// tb_led4_flash_bl
// Self-checking bench for led4_flash_bl with HOLD_TICKS=3, GAP_TICKS=2,
// MAX_PEND=3. Per-cycle expected waveforms are written as 32-bit strings,
// leftmost bit = first cycle after the first strobe edge.
// ---------------------------------------------------------------------------
module tb_led4_flash_bl;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       clr;
  logic [3:0] st;
  logic [3:0] led;
  logic [3:0] busy;
  logic [3:0] ovf;

  int n_chk;
  int n_fail;

  logic [3:0] e_led;
  logic [3:0] e_busy;
  logic [3:0] e_ovf;

  typedef struct {
    int          ch;
    int          n_st;      // strobes on cycles 0..n_st-1
    int          extra_at;  // one additional strobe cycle, -1 for none
    logic [31:0] exp_led;
    logic [31:0] exp_busy;
    logic [31:0] exp_ovf;
  } vec_t;

  vec_t vecs[5];

  led4_flash_bl #(
    .HOLD_TICKS (3),
    .GAP_TICKS  (2),
    .MAX_PEND   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .clr   (clr),
    .st    (st),
    .led   (led),
    .busy  (busy),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    clr = 1'b1;
    st  = 4'b0000;
    ce  = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    // Single pulse: 3 on, 2 off, then idle.
    vecs[0] = '{0, 1, -1,
                32'b11100000_00000000_00000000_00000000,
                32'b11111000_00000000_00000000_00000000,
                32'b00000000_00000000_00000000_00000000};
    // Three back-to-back strobes: three flashes, no overflow.
    vecs[1] = '{1, 3, -1,
                32'b11100111_00111000_00000000_00000000,
                32'b11111111_11111110_00000000_00000000,
                32'b00000000_00000000_00000000_00000000};
    // Five strobes: queue saturates, 5th dropped, four flashes.
    vecs[2] = '{2, 5, -1,
                32'b11100111_00111001_11000000_00000000,
                32'b11111111_11111111_11110000_00000000,
                32'b00001000_00000000_00000000_00000000};
    // Strobe exactly on the gap-exit edge: straight back to ON.
    vecs[3] = '{3, 1, 5,
                32'b11100111_00000000_00000000_00000000,
                32'b11111111_11000000_00000000_00000000,
                32'b00000000_00000000_00000000_00000000};
    // Strobe on the ON->GAP edge is queued and replayed after the gap.
    vecs[4] = '{0, 1, 3,
                32'b11100111_00000000_00000000_00000000,
                32'b11111111_11000000_00000000_00000000,
                32'b00000000_00000000_00000000_00000000};

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    ce     = 1'b0;
    clr    = 1'b0;
    st     = 4'b0000;

    // Reset state.
    #1;
    chk("reset led", led, 4'b0000);
    chk("reset busy", busy, 4'b0000);
    chk("reset ovf", ovf, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven scenarios with ce high every cycle.
    for (int i = 0; i < 5; i++) begin
      clear_all();
      for (int c = 0; c < 32; c++) begin
        ce = 1'b1;
        st = 4'b0000;
        st[vecs[i].ch] = (c < vecs[i].n_st) || (c == vecs[i].extra_at);
        step();
        e_led  = 4'b0000;
        e_busy = 4'b0000;
        e_ovf  = 4'b0000;
        e_led[vecs[i].ch]  = vecs[i].exp_led[31-c];
        e_busy[vecs[i].ch] = vecs[i].exp_busy[31-c];
        e_ovf[vecs[i].ch]  = vecs[i].exp_ovf[31-c];
        chk($sformatf("v%0d c%0d led", i, c), led, e_led);
        chk($sformatf("v%0d c%0d busy", i, c), busy, e_busy);
        chk($sformatf("v%0d c%0d ovf", i, c), ovf, e_ovf);
      end
    end

    // Sparse ce: ce high on cycles 2,6,10,14,18 after entry on cycle 0.
    // ON ends at the 3rd tick (cycle 10), GAP ends at the 5th (cycle 18).
    clear_all();
    for (int c = 0; c < 22; c++) begin
      ce = ((c % 4) == 2);
      st = (c == 0) ? 4'b1000 : 4'b0000;
      step();
      chk($sformatf("slow c%0d led", c), led, (c < 10) ? 4'b1000 : 4'b0000);
      chk($sformatf("slow c%0d busy", c), busy, (c < 18) ? 4'b1000 : 4'b0000);
    end

    // Asynchronous reset mid-flash, then no resume.
    clear_all();
    ce = 1'b1;
    st = 4'b0011;
    step();
    st = 4'b0000;
    step();
    chk("pre-rst led", led, 4'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst led", led, 4'b0000);
    chk("async rst busy", busy, 4'b0000);
    chk("async rst ovf", ovf, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("post-rst c%0d busy", c), busy, 4'b0000);
    end

    // clr with a full queue on channel 2 and strobes on all channels.
    clear_all();
    ce = 1'b0;
    st = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      step();
    end
    chk("pre-clr led", led, 4'b0100);
    chk("pre-clr ovf", ovf, 4'b0000);
    clr = 1'b1;
    st  = 4'b1111;
    step();
    clr = 1'b0;
    st  = 4'b0000;
    ce  = 1'b1;
    chk("clr led", led, 4'b0000);
    chk("clr busy", busy, 4'b0000);
    chk("clr ovf", ovf, 4'b0000);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("post-clr c%0d busy", c), busy, 4'b0000);
      chk($sformatf("post-clr c%0d ovf", c), ovf, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
